// File: rtl/control_fsm.sv
// control_fsm: multi-cycle control unit for the 16-bit processor.
//
// Sequences each instruction through FETCH / DECODE / EXEC / MEM / WB.
// The unit issues one-cycle register-write and PC-load strobes, holds a memory
// request until mem_ready arrives, and resolves conditional branches from the
// Z/N flags. An undefined opcode or a memory wait of WAIT_MAX cycles faults
// into HALT, which only a reset leaves.
//
// Opcode map (5-bit instruction field):
//   00000 mv     00001 add    00010 sub    00011 cmp    00100 ld
//   00101 st     00111 mvi    01000 mvhi   01001 addi   01010 subi
//   01011 cmpi   01100 j      01101 jz     01110 jn     01111 jr
//   10000 jzr    10001 jnr    10010 callr  10011 call
//   All other codes (including 00110) are undefined.
//
// Ports:
//   clk, reset_n          clock (rising edge), asynchronous active-low reset
//   opcode                instruction register opcode, valid from DECODE on
//   Z, N                  registered datapath flags, used in EXEC
//   mem_ready             memory completes the current request this cycle
//   mem_req, mem_sel      memory request (held until ready), 1 = fetch
//   ir_load               instruction register load strobe
//   ALUOp, ALUSrc, ExtSel ALU add/sub, Ry/immediate, imm8/imm11
//   RegWrite, RegDst      register write strobe, destination Rx/R7
//   WBSrc                 write-back source select
//   MemWrite              data write strobe
//   NZ                    flag update strobe
//   PCSrc                 PC source: 00 pc+imm11, 01 Ry, 10 pc+2
//   pc_enable             PC load strobe, one per retired instruction
//   halted, fault_code    HALT indicator, sticky fault cause
//   instr_count           retired-instruction counter (wraps)
module control_fsm #(
  parameter int unsigned WAIT_MAX         = 15,
  parameter int unsigned CNT_W            = 16,
  parameter bit          FAULT_ON_ILLEGAL = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [4:0]       opcode,
  input  logic             Z,
  input  logic             N,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_sel,
  output logic             ir_load,
  output logic             ALUOp,
  output logic             ALUSrc,
  output logic             ExtSel,
  output logic             RegWrite,
  output logic             RegDst,
  output logic [2:0]       WBSrc,
  output logic             MemWrite,
  output logic             NZ,
  output logic [1:0]       PCSrc,
  output logic             pc_enable,
  output logic             halted,
  output logic [1:0]       fault_code,
  output logic [CNT_W-1:0] instr_count
);

  // The wait counter only ever has to hold WAIT_MAX-1.
  localparam int unsigned      WAIT_W    = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_MAX - 1);

  localparam logic [4:0] OP_MV    = 5'b00000;
  localparam logic [4:0] OP_ADD   = 5'b00001;
  localparam logic [4:0] OP_SUB   = 5'b00010;
  localparam logic [4:0] OP_CMP   = 5'b00011;
  localparam logic [4:0] OP_LD    = 5'b00100;
  localparam logic [4:0] OP_ST    = 5'b00101;
  localparam logic [4:0] OP_MVI   = 5'b00111;
  localparam logic [4:0] OP_MVHI  = 5'b01000;
  localparam logic [4:0] OP_ADDI  = 5'b01001;
  localparam logic [4:0] OP_SUBI  = 5'b01010;
  localparam logic [4:0] OP_CMPI  = 5'b01011;
  localparam logic [4:0] OP_J     = 5'b01100;
  localparam logic [4:0] OP_JZ    = 5'b01101;
  localparam logic [4:0] OP_JN    = 5'b01110;
  localparam logic [4:0] OP_JR    = 5'b01111;
  localparam logic [4:0] OP_JZR   = 5'b10000;
  localparam logic [4:0] OP_JNR   = 5'b10001;
  localparam logic [4:0] OP_CALLR = 5'b10010;
  localparam logic [4:0] OP_CALL  = 5'b10011;

  localparam logic [1:0] FAULT_NONE    = 2'b00;
  localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {
    S_RST, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  state_t            state_reg, state_next;
  logic [4:0]        op_reg, op_next;
  logic [WAIT_W-1:0] wait_reg, wait_next;
  logic [1:0]        fault_reg, fault_next;
  logic [CNT_W-1:0]  count_reg, count_next;

  logic op_defined;
  logic op_is_mem;

  assign op_is_mem  = (opcode == OP_LD) || (opcode == OP_ST);
  assign op_defined = opcode inside {OP_MV, OP_ADD, OP_SUB, OP_CMP, OP_LD, OP_ST,
                                     OP_MVI, OP_MVHI, OP_ADDI, OP_SUBI, OP_CMPI,
                                     OP_J, OP_JZ, OP_JN, OP_JR, OP_JZR, OP_JNR,
                                     OP_CALLR, OP_CALL};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= S_RST;
      op_reg    <= '0;
      wait_reg  <= '0;
      fault_reg <= FAULT_NONE;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      op_reg    <= op_next;
      wait_reg  <= wait_next;
      fault_reg <= fault_next;
      count_reg <= count_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    op_next    = op_reg;
    wait_next  = wait_reg;
    fault_next = fault_reg;
    mem_req    = 1'b0;
    mem_sel    = 1'b0;
    ir_load    = 1'b0;
    ALUOp      = 1'b0;
    ALUSrc     = 1'b0;
    ExtSel     = 1'b0;
    RegWrite   = 1'b0;
    RegDst     = 1'b0;
    WBSrc      = 3'b001;
    MemWrite   = 1'b0;
    NZ         = 1'b0;
    PCSrc      = 2'b10;
    pc_enable  = 1'b0;
    halted     = 1'b0;

    unique case (state_reg)
      S_RST: begin
        state_next = S_FETCH;
        wait_next  = '0;
      end

      S_FETCH: begin
        mem_req = 1'b1;
        mem_sel = 1'b1;
        if (mem_ready) begin
          ir_load    = 1'b1;
          state_next = S_DECODE;
        end else if (wait_reg == WAIT_LAST) begin
          state_next = S_HALT;
          fault_next = FAULT_TIMEOUT;
        end else begin
          wait_next = wait_reg + 1'b1;
        end
      end

      S_DECODE: begin
        op_next = opcode;
        if (op_is_mem) begin
          state_next = S_MEM;
          wait_next  = '0;
        end else if (op_defined || !FAULT_ON_ILLEGAL) begin
          state_next = S_EXEC;
        end else begin
          state_next = S_HALT;
          fault_next = FAULT_ILLEGAL;
        end
      end

      S_EXEC: begin
        pc_enable  = 1'b1;
        state_next = S_FETCH;
        wait_next  = '0;
        unique case (op_reg)
          OP_MV: begin
            RegWrite = 1'b1;
            WBSrc    = 3'b011;
          end
          OP_ADD, OP_SUB: begin
            RegWrite = 1'b1;
            ALUOp    = (op_reg == OP_SUB);
            NZ       = 1'b1;
          end
          OP_CMP: begin
            ALUOp = 1'b1;
            NZ    = 1'b1;
          end
          OP_CMPI: begin
            ALUOp  = 1'b1;
            ALUSrc = 1'b1;
            NZ     = 1'b1;
          end
          OP_MVI: begin
            RegWrite = 1'b1;
            WBSrc    = 3'b100;
          end
          OP_MVHI: begin
            RegWrite = 1'b1;
            WBSrc    = 3'b101;
          end
          OP_ADDI, OP_SUBI: begin
            RegWrite = 1'b1;
            ALUOp    = (op_reg == OP_SUBI);
            ALUSrc   = 1'b1;
            NZ       = 1'b1;
          end
          // Relative branches target pc+imm11; not taken falls through to pc+2.
          OP_J, OP_JZ, OP_JN: begin
            ExtSel = 1'b1;
            if ((op_reg == OP_J) || (op_reg == OP_JZ && Z) || (op_reg == OP_JN && N))
              PCSrc = 2'b00;
          end
          OP_JR, OP_JZR, OP_JNR: begin
            if ((op_reg == OP_JR) || (op_reg == OP_JZR && Z) || (op_reg == OP_JNR && N))
              PCSrc = 2'b01;
          end
          // Calls save the return address (pc+2) into R7.
          OP_CALL, OP_CALLR: begin
            RegWrite = 1'b1;
            RegDst   = 1'b1;
            WBSrc    = 3'b010;
            ExtSel   = (op_reg == OP_CALL);
            PCSrc    = (op_reg == OP_CALL) ? 2'b00 : 2'b01;
          end
          // Only reachable for undefined opcodes when they retire as a NOP.
          default: ;
        endcase
      end

      S_MEM: begin
        mem_req  = 1'b1;
        MemWrite = (op_reg == OP_ST);
        if (mem_ready) begin
          if (op_reg == OP_ST) begin
            pc_enable  = 1'b1;
            state_next = S_FETCH;
            wait_next  = '0;
          end else begin
            state_next = S_WB;
          end
        end else if (wait_reg == WAIT_LAST) begin
          state_next = S_HALT;
          fault_next = FAULT_TIMEOUT;
        end else begin
          wait_next = wait_reg + 1'b1;
        end
      end

      S_WB: begin
        RegWrite   = 1'b1;
        WBSrc      = 3'b000;
        pc_enable  = 1'b1;
        state_next = S_FETCH;
        wait_next  = '0;
      end

      S_HALT: begin
        halted = 1'b1;
      end

      default: begin
        state_next = S_RST;
      end
    endcase

    count_next = count_reg + CNT_W'(pc_enable);
  end

  assign fault_code  = fault_reg;
  assign instr_count = count_reg;

endmodule

// File: doc/control_fsm.md
# control_fsm

Multi-cycle control unit for the 16-bit processor. It replaces the single-cycle opcode decode with a FETCH/DECODE/EXEC/MEM/WB state machine. The machine issues one-cycle write/PC strobes, waits on a memory ready handshake, and resolves conditional branches internally from the Z/N flags. It also adds ld/st/jr/jzr/jnr/callr/call, illegal-opcode and memory-timeout faulting, and a retired-instruction counter. It sits between the instruction register/flags and the datapath muxes/enables.

## Interface
- `WAIT_MAX`, default 15: maximum cycles spent waiting on `mem_ready` in one FETCH or MEM visit before faulting (≥1).
- `CNT_W`, default 16: width of the retired-instruction counter.
- `FAULT_ON_ILLEGAL`, default 1:
  - 1: an undefined opcode enters HALT.
  - 0: an undefined opcode retires as a NOP (pc+2).
- `clk`  in  1  sole clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `opcode`  in  5  instruction register opcode field, valid from the DECODE cycle on.
- `Z`, `N`  in  1 each  registered flags from the datapath.
- `mem_ready`  in  1  memory completes the current request this cycle.
- `mem_req`  out  1  memory request, held until `mem_ready`.
- `mem_sel`  out  1  1 = instruction fetch, 0 = data access.
- `ir_load`  out  1  load the instruction register.
- `ALUOp`  out  1  0 = add, 1 = sub.
- `ALUSrc`  out  1  0 = Ry, 1 = sign-extended immediate.
- `ExtSel`  out  1  0 = imm8, 1 = imm11.
- `RegWrite`  out  1  register file write strobe.
- `RegDst`  out  1  0 = Rx, 1 = R7.
- `WBSrc`  out  3  write-back source:
  - 000 = mem, 001 = alu, 010 = pc+2, 011 = Ry, 100 = imm8, 101 = imm8<<8.
- `MemWrite`  out  1  data write strobe.
- `NZ`  out  1  update flags.
- `PCSrc`  out  2  PC source:
  - 00 = pc+imm11, 01 = Ry, 10 = pc+2.
- `pc_enable`  out  1  PC load strobe, exactly one per retired instruction.
- `halted`  out  1  FSM is in HALT.
- `fault_code`  out  2  sticky fault cause:
  - 00 = none, 01 = illegal opcode, 10 = memory timeout.
- `instr_count`  out  `CNT_W`  retired instructions, wraps modulo 2^`CNT_W`.

## Operation
- States: RST, FETCH, DECODE, EXEC, MEM, WB, HALT.
- Reset state is RST. In RST all strobes and `mem_req` are 0, `PCSrc` = 10, `WBSrc` = 001, `fault_code` = 00, `instr_count` = 0, `halted` = 0.
- RST→FETCH on the first clock after `reset_n` deasserts.
- FETCH:
  - Drives `mem_req` = 1, `mem_sel` = 1.
  - On `mem_ready`: `ir_load` = 1 for that cycle, then →DECODE.
- DECODE: registers `opcode` into `op_q`; all strobes 0.
  - ld/st → MEM.
  - Defined non-memory opcodes → EXEC.
  - Undefined opcode → HALT (fault 01) if `FAULT_ON_ILLEGAL` = 1, else EXEC as NOP.
- EXEC: all datapath outputs decode from `op_q`. `RegWrite`, `NZ` and `pc_enable` strobe here for one cycle, then →FETCH.
  - mv: `WBSrc` = 011.
  - add/sub: `ALUSrc` = 0, `WBSrc` = 001, `NZ` = 1.
  - cmp/cmpi: no `RegWrite`, `NZ` = 1.
  - mvi: `WBSrc` = 100.
  - mvhi: `WBSrc` = 101.
  - addi/subi: `ALUSrc` = 1, `ExtSel` = 0, `NZ` = 1.
  - j/jz/jn: `ExtSel` = 1; branch taken → `PCSrc` = 00.
  - jr/jzr/jnr: branch taken → `PCSrc` = 01.
  - Condition: unconditional, Z = 1 for z-forms, N = 1 for n-forms. A not-taken branch → `PCSrc` = 10. Branches never write a register.
  - call/callr: `RegWrite` = 1, `RegDst` = 1, `WBSrc` = 010, `PCSrc` = 00 / 01.
- MEM: `mem_req` = 1, `mem_sel` = 0.
  - st: `MemWrite` = 1 while waiting. On `mem_ready`: `pc_enable` = 1, `PCSrc` = 10, then →FETCH.
  - ld: on `mem_ready` →WB.
- WB (ld only): `RegWrite` = 1, `WBSrc` = 000, `RegDst` = 0, `pc_enable` = 1, then →FETCH.
- Timeout: a wait counter clears on entry to FETCH/MEM and increments each cycle without `mem_ready`.
  - Reaching `WAIT_MAX` without `mem_ready` → HALT, fault 10.
  - `mem_ready` in the same cycle as the limit wins; no fault.
- HALT: absorbing until reset. All strobes and `mem_req` are 0, `halted` = 1, `fault_code` holds.
- `instr_count` increments on every `pc_enable` cycle.
- Outputs are combinational from the registered state and `op_q` only. Inputs other than `mem_ready`, `Z`, `N` never affect the current cycle.
- Reset mid-instruction aborts it. No strobe is issued in the reset cycle.

## Timing
- Instruction latency with `mem_ready` high on every request:
  - Non-memory instruction: 3 cycles (FETCH, DECODE, EXEC).
  - st: 3 cycles (FETCH, DECODE, MEM).
  - ld: 4 cycles (FETCH, DECODE, MEM, WB).
- Each cycle of `mem_ready` low adds one cycle in FETCH or MEM.
- `Z`/`N` are sampled in EXEC. A branch immediately after cmp sees the flags updated at cmp's EXEC clock edge.
- `RegWrite`, `MemWrite` (st completion), `ir_load` and `pc_enable` are never high for more than one cycle per instruction.

## Test plan
- Reset, then an add stream with `mem_ready` = 1: `pc_enable` every 3rd cycle, `RegWrite`/`NZ` in EXEC only; after 4 instructions `instr_count` = 4.
- cmp with datapath driving Z = 1, then jz: `PCSrc` = 00 in jz's EXEC. Repeat with Z = 0: `PCSrc` = 10. No `RegWrite` on either branch.
- ld with `mem_ready` delayed 3 cycles in MEM: 7 cycles total. `RegWrite` with `WBSrc` = 000 is in WB, not MEM.
- callr: `RegWrite` = 1, `RegDst` = 1, `WBSrc` = 010, `PCSrc` = 01 in the same EXEC cycle.
- `mem_ready` held 0 in FETCH with `WAIT_MAX` = 15: `halted` = 1 and `fault_code` = 10 after 15 cycles. `mem_ready` arriving on cycle 15 instead: no fault.
- Opcode 5'b00110:
  - `FAULT_ON_ILLEGAL` = 1: HALT, `fault_code` = 01.
  - `FAULT_ON_ILLEGAL` = 0: retires with `PCSrc` = 10 and no writes.
  - `reset_n` pulse during HALT clears the fault and restarts fetch.
